// File: rtl/eth_xcvr_reset_seq.sv
// Reset/bring-up sequencer for one GTY quad channel: QPLL, TX and RX datapath resets,
// then RX block-lock acquisition, with timeouts, retries and loss-of-lock recovery.
module eth_xcvr_reset_seq #(
   parameter int unsigned QPLL_RST_CYCLES = 16,
   parameter int unsigned DP_RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT    = 65536,
   parameter int unsigned LOSS_FILTER     = 128,
   parameter int unsigned RETRY_W         = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               gtpowergood,
   input  logic               qpll_lock,
   input  logic               tx_reset_done,
   input  logic               rx_reset_done,
   input  logic               rx_block_lock,
   output logic               qpll_reset,
   output logic               tx_reset,
   output logic               rx_reset,
   output logic               tx_ready,
   output logic               rx_ready,
   output logic [3:0]         state_out,
   output logic [RETRY_W-1:0] retry_count
);

   localparam int unsigned RST_MAX = (QPLL_RST_CYCLES > DP_RST_CYCLES) ? QPLL_RST_CYCLES : DP_RST_CYCLES;
   localparam int unsigned TMAX    = (LOCK_TIMEOUT > RST_MAX) ? LOCK_TIMEOUT : RST_MAX;
   localparam int unsigned TW      = $clog2(TMAX);
   localparam int unsigned LW      = $clog2(LOSS_FILTER + 1);

   localparam logic [TW-1:0] QR_LAST = TW'(QPLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] DP_LAST = TW'(DP_RST_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [LW-1:0] LF_LAST = LW'(LOSS_FILTER - 1);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_QPLL_RST  = 4'd1,
      ST_QPLL_WAIT = 4'd2,
      ST_TX_RST    = 4'd3,
      ST_TX_WAIT   = 4'd4,
      ST_RX_RST    = 4'd5,
      ST_RX_WAIT   = 4'd6,
      ST_LOCK_WAIT = 4'd7,
      ST_UP        = 4'd8
   } state_t;

   state_t        state, state_next;
   logic [TW-1:0] timer;
   logic [LW-1:0] loss;
   logic          retry_inc;
   logic [4:0]    sync1, sync2;
   logic          pg_s, ql_s, td_s, rd_s, bl_s;
   logic          qpll_reset_next, tx_reset_next, rx_reset_next, tx_ready_next, rx_ready_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {gtpowergood, qpll_lock, tx_reset_done, rx_reset_done, rx_block_lock};
         sync2 <= sync1;
      end
   end

   assign {pg_s, ql_s, td_s, rd_s, bl_s} = sync2;

   // Priority: powergood loss, then QPLL loss (stages 3..8), then per-state done/timeout.
   always_comb begin
      state_next = state;
      retry_inc  = 1'b0;
      if (state != ST_IDLE && !pg_s) begin
         state_next = ST_IDLE;
      end else if (state >= ST_TX_RST && !ql_s) begin
         state_next = ST_QPLL_RST;
         retry_inc  = 1'b1;
      end else begin
         case (state)
            ST_IDLE:      if (pg_s) state_next = ST_QPLL_RST;
            ST_QPLL_RST:  if (timer == QR_LAST) state_next = ST_QPLL_WAIT;
            ST_QPLL_WAIT: begin
               if (ql_s) begin
                  state_next = ST_TX_RST;
               end else if (timer == TO_LAST) begin
                  state_next = ST_QPLL_RST;
                  retry_inc  = 1'b1;
               end
            end
            ST_TX_RST:    if (timer == DP_LAST) state_next = ST_TX_WAIT;
            ST_TX_WAIT: begin
               if (td_s) begin
                  state_next = ST_RX_RST;
               end else if (timer == TO_LAST) begin
                  state_next = ST_TX_RST;
                  retry_inc  = 1'b1;
               end
            end
            ST_RX_RST:    if (timer == DP_LAST) state_next = ST_RX_WAIT;
            ST_RX_WAIT: begin
               if (rd_s) begin
                  state_next = ST_LOCK_WAIT;
               end else if (timer == TO_LAST) begin
                  state_next = ST_RX_RST;
                  retry_inc  = 1'b1;
               end
            end
            ST_LOCK_WAIT: begin
               if (bl_s) begin
                  state_next = ST_UP;
               end else if (timer == TO_LAST) begin
                  state_next = ST_RX_RST;
                  retry_inc  = 1'b1;
               end
            end
            ST_UP: begin
               if (!bl_s && loss == LF_LAST) begin
                  state_next = ST_RX_RST;
                  retry_inc  = 1'b1;
               end
            end
            default:      state_next = ST_IDLE;
         endcase
      end

      qpll_reset_next = (state_next == ST_IDLE) || (state_next == ST_QPLL_RST);
      tx_reset_next   = (state_next <= ST_TX_RST);
      rx_reset_next   = (state_next <= ST_RX_RST);
      tx_ready_next   = (state_next >= ST_RX_RST);
      rx_ready_next   = (state_next == ST_UP);
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         timer       <= '0;
         loss        <= '0;
         retry_count <= '0;
         qpll_reset  <= 1'b1;
         tx_reset    <= 1'b1;
         rx_reset    <= 1'b1;
         tx_ready    <= 1'b0;
         rx_ready    <= 1'b0;
      end else begin
         state       <= state_next;
         timer       <= (state_next != state) ? '0 : timer + TW'(1);
         loss        <= (state == ST_UP && state_next == ST_UP && !bl_s) ? loss + LW'(1) : '0;
         if (retry_inc && retry_count != '1) retry_count <= retry_count + RETRY_W'(1);
         qpll_reset  <= qpll_reset_next;
         tx_reset    <= tx_reset_next;
         rx_reset    <= rx_reset_next;
         tx_ready    <= tx_ready_next;
         rx_ready    <= rx_ready_next;
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_eth_xcvr_reset_seq.sv
// Scoreboard bench for eth_xcvr_reset_seq: a table-driven stage model predicts every cycle's outputs.
module tb_eth_xcvr_reset_seq;

   localparam int QR = 4;
   localparam int DP = 4;
   localparam int TO = 64;
   localparam int LF = 8;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pg = 1'b0, ql = 1'b0, td = 1'b0, rd = 1'b0, bl = 1'b0;
   logic          qpll_reset, tx_reset, rx_reset, tx_ready, rx_ready;
   logic [3:0]    state_out;
   logic [RW-1:0] retry_count;

   int n_cmp = 0;
   int n_err = 0;

   eth_xcvr_reset_seq #(
      .QPLL_RST_CYCLES(QR),
      .DP_RST_CYCLES  (DP),
      .LOCK_TIMEOUT   (TO),
      .LOSS_FILTER    (LF),
      .RETRY_W        (RW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .gtpowergood  (pg),
      .qpll_lock    (ql),
      .tx_reset_done(td),
      .rx_reset_done(rd),
      .rx_block_lock(bl),
      .qpll_reset   (qpll_reset),
      .tx_reset     (tx_reset),
      .rx_reset     (rx_reset),
      .tx_ready     (tx_ready),
      .rx_ready     (rx_ready),
      .state_out    (state_out),
      .retry_count  (retry_count)
   );

   always #4 clk = ~clk;

   // Stage table. Status vector bits: 4 powergood, 3 qpll_lock, 2 tx_done, 1 rx_done, 0 block_lock.
   int hold_tab[9] = '{0, QR, 0, DP, 0, DP, 0, 0, 0};
   int done_bit[9] = '{4, -1, 3, -1, 2, -1, 1, 0, -1};
   int fail_to[9]  = '{-1, -1, 1, -1, 3, -1, 5, 5, -1};
   logic [8:0] qr_on  = 9'b0_0000_0011;
   logic [8:0] tr_on  = 9'b0_0000_1111;
   logic [8:0] rr_on  = 9'b0_0011_1111;
   logic [8:0] txr_on = 9'b1_1110_0000;
   logic [8:0] rxr_on = 9'b1_0000_0000;

   int         m_stage, m_t, m_loss, m_retry;
   logic [4:0] hist[$];
   logic [4:0] m_d;
   logic [16:0] sb[$];
   logic [16:0] mon_exp;

   function automatic logic [16:0] expect_vec(input int st, input int rt);
      return {4'(st), qr_on[st], tr_on[st], rr_on[st], txr_on[st], rxr_on[st], 8'(rt)};
   endfunction

   task automatic model_step(input logic [4:0] d);
      int  nxt;
      bit  bump;
      nxt  = m_stage;
      bump = 0;
      if (m_stage != 0 && !d[4]) begin
         nxt = 0;
      end else if (m_stage >= 3 && !d[3]) begin
         nxt = 1; bump = 1;
      end else if (hold_tab[m_stage] > 0) begin
         if (m_t + 1 >= hold_tab[m_stage]) nxt = m_stage + 1;
      end else if (done_bit[m_stage] >= 0 && d[done_bit[m_stage]]) begin
         nxt = m_stage + 1;
      end else if (fail_to[m_stage] >= 0 && m_t == TO - 1) begin
         nxt = fail_to[m_stage]; bump = 1;
      end else if (m_stage == 8 && !d[0] && m_loss + 1 >= LF) begin
         nxt = 5; bump = 1;
      end
      m_loss  = (m_stage == 8 && nxt == 8 && !d[0]) ? m_loss + 1 : 0;
      m_t     = (nxt != m_stage) ? 0 : m_t + 1;
      if (bump && m_retry < (1 << RW) - 1) m_retry++;
      m_stage = nxt;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_stage = 0; m_t = 0; m_loss = 0; m_retry = 0;
         hist.delete();
         hist.push_back(5'b0);
         hist.push_back(5'b0);
      end else begin
         m_d = hist.pop_front();
         hist.push_back({pg, ql, td, rd, bl});
         model_step(m_d);
      end
      sb.push_back(expect_vec(m_stage, m_retry));
   end

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (sb.size() > 0) begin
         mon_exp = sb.pop_front();
         check("scoreboard", {state_out, qpll_reset, tx_reset, rx_reset, tx_ready, rx_ready, retry_count}, mon_exp);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_stage(input int s, input int budget, input string name);
      int i;
      i = 0;
      while (int'(state_out) != s && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, 17'(state_out), 17'(s));
   endtask

   task automatic pulse_rst(input string name);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check(name, {state_out, qpll_reset, tx_reset, rx_reset, tx_ready, rx_ready, retry_count},
            {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [4:0] v);
      {pg, ql, td, rd, bl} = v;
   endtask

   int r0;

   initial begin
      cyc(3);
      check("reset_vals", {state_out, qpll_reset, tx_reset, rx_reset, tx_ready, rx_ready, retry_count},
            {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      rst_n = 1'b1;

      // Nominal bring-up
      cyc(3);
      drive(5'b11111);
      wait_stage(8, 200, "nominal_up");
      check("nominal_retry", 17'(retry_count), 17'(0));

      // QPLL never locks: periodic timeouts from a clean reset
      pulse_rst("rst_before_qpll_to");
      drive(5'b10111);
      wait_stage(2, 50, "qpll_wait_reached");
      cyc(210);
      check("qpll_to_retry3", 17'(retry_count), 17'(3));

      // Loss filter in UP
      drive(5'b11111);
      wait_stage(8, 300, "up_again");
      bl = 1'b0;
      cyc(7);
      bl = 1'b1;
      cyc(20);
      check("short_loss_stays_up", 17'(state_out), 17'(8));
      r0 = m_retry;
      bl = 1'b0;
      wait_stage(5, 20, "long_loss_rx_rst");
      check("long_loss_ready", {15'(retry_count), tx_ready, rx_ready}, {15'(r0 + 1), 1'b1, 1'b0});
      bl = 1'b1;

      // QPLL loss in UP
      wait_stage(8, 300, "up_before_qpll_loss");
      ql = 1'b0;
      cyc(3);
      check("qpll_loss_outputs", {11'(state_out), qpll_reset, tx_reset, rx_reset, tx_ready, rx_ready},
            {11'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

      // Powergood and QPLL drop together in TX_WAIT
      ql = 1'b1;
      td = 1'b0;
      wait_stage(4, 200, "tx_wait_reached");
      cyc(5);
      r0 = m_retry;
      pg = 1'b0;
      ql = 1'b0;
      cyc(5);
      check("simul_drop_idle", {9'(state_out), retry_count}, {9'd0, 8'(r0)});

      // Reset pulse in LOCK_WAIT, then restart
      drive(5'b11110);
      wait_stage(7, 300, "lock_wait_reached");
      pulse_rst("async_rst_lock_wait");
      bl = 1'b1;
      wait_stage(8, 300, "restart_up");

      // Retry counter saturation
      ql = 1'b0;
      cyc(300 * (QR + TO) + 100);
      check("retry_saturate", 17'(retry_count), 17'(255));

      // Random segments, mostly-healthy status with occasional resets
      pulse_rst("rst_before_random");
      for (int seg = 0; seg < 80; seg++) begin
         logic [4:0] v;
         v[4] = ($urandom_range(0, 99) < 92);
         v[3] = ($urandom_range(0, 99) < 82);
         v[2] = ($urandom_range(0, 99) < 85);
         v[1] = ($urandom_range(0, 99) < 85);
         v[0] = ($urandom_range(0, 99) < 75);
         if ($urandom_range(0, 19) == 0) pulse_rst("rand_rst");
         drive(v);
         cyc($urandom_range(1, 90));
      end

      cyc(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
